wb_lite_initiator: RTL and testbench

WB_LITE_INITIATOR -- requirements
Module: wb_lite_initiator

---
 rtl/wbm_pkg.sv | 25 ++
 rtl/wbm_timeout_ctr.sv | 40 ++++
 rtl/wb_lite_initiator.sv | 155 +++++++++++++++
 tb/tb_wb_lite_initiator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone-lite initiator.
// Holds the initiator state enum, the default timeout and the timeout
// counter width/load helper used when WBM_TIMEOUT_EN is defined.
package wbm_pkg;

    // state   | meaning
    // IDLE    | ready for a command, no bus activity
    // BUS     | cyc/stb asserted, waiting for slave ack/err (or timeout)
    // RESP    | response presented, waiting for rsp_ready_i
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wbm_state_e;

    localparam int unsigned WBM_TIMEOUT_DEFAULT = 255;
    localparam int unsigned WBM_TMO_W           = 16;

    // Load value for the down-counter: terminal count is reached after
    // exactly 'cycles' enabled cycles.
    function automatic logic [WBM_TMO_W-1:0] wbm_tmo_load(input int unsigned cycles);
        return WBM_TMO_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/wbm_timeout_ctr.sv
// Bus-cycle timeout down-counter. Loaded on clear, counts down while
// enabled, and flags expiry in the enabled cycle where it sits at zero,
// i.e. after TIMEOUT_CYCLES enabled cycles.
module wbm_timeout_ctr
    import wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WBM_TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [WBM_TMO_W-1:0] cnt_q;
    logic [WBM_TMO_W-1:0] cnt_d;

    // Next count: reload on clear, otherwise decrement toward terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = wbm_tmo_load(TIMEOUT_CYCLES);
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/wb_lite_initiator.sv
// Wishbone classic initiator with a simple command/response handshake.
// One transfer outstanding: IDLE -> BUS -> RESP -> IDLE.
// Optional macro WBM_TIMEOUT_EN adds a bus timeout that ends a transfer
// with an error response after TIMEOUT_CYCLES cycles without ack/err.
//
// state   | meaning
// IDLE    | cmd_ready_o high, waiting for cmd_valid_i
// BUS     | cyc/stb high with registered command, waiting for ack/err
// RESP    | rsp_valid_o high, response held until rsp_ready_i
module wb_lite_initiator
    import wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = WBM_TIMEOUT_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    // Out-of-range timeouts cannot be represented by the 16-bit counter.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wb_lite_initiator: TIMEOUT_CYCLES must be within 1..65535");
    end

    wbm_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

    logic in_bus;
    logic handshake;
    logic tmo_expired;

    assign in_bus    = (state_q == ST_BUS);
    assign handshake = cmd_valid_i && cmd_ready_o;

`ifdef WBM_TIMEOUT_EN
    wbm_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .clear_i   (handshake),
        .enable_i  (in_bus),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // Next-state and datapath capture; ack/err outrank a same-cycle timeout.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    state_d   = ST_BUS;
                    we_d      = cmd_we_i;
                    adr_d     = cmd_adr_i;
                    dat_d     = cmd_we_i ? cmd_dat_i : 32'h0;
                    sel_d     = cmd_sel_i;
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b0;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i || wbm_err_i) begin
                    state_d   = ST_RESP;
                    rsp_err_d = wbm_err_i;
                    rsp_dat_d = (wbm_ack_i && !wbm_err_i && !we_q) ? wbm_dat_i : 32'h0;
                end else if (tmo_expired) begin
                    state_d   = ST_RESP;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = 32'h0;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured command/response registers; reset aborts any transfer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    // Ready is withheld while reset is applied even though state reads IDLE.
    assign cmd_ready_o = (state_q == ST_IDLE) && !wb_rst_i;

    // Bus outputs are only meaningful in BUS; they read zero elsewhere.
    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus && we_q;
    assign wbm_sel_o = in_bus ? sel_q : 4'h0;
    assign wbm_adr_o = in_bus ? adr_q : 32'h0;
    assign wbm_dat_o = in_bus ? dat_q : 32'h0;

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_lite_initiator.sv
// Self-checking bench for wb_lite_initiator (table-driven transfers plus
// hand-written reset, idle-ack and timeout sequences).
module tb_wb_lite_initiator;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    wb_lite_initiator #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_adr_i   (cmd_adr_i),
        .cmd_dat_i   (cmd_dat_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_dat_o   (rsp_dat_o),
        .rsp_err_o   (rsp_err_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_dat_i   (wbm_dat_i),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_err_i   (wbm_err_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          waits;
        logic        ack;
        logic        err;
        logic [31:0] sdat;
        int          hold;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_compare(input string tag);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_sb_empty: got response expected none queued", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_rsp_dat"}, rsp_dat_o, e.dat);
            check({tag, "_rsp_err"}, {31'b0, rsp_err_o}, {31'b0, e.err});
        end
    endtask

    // Accept response at current negedge (state RESP), then confirm IDLE.
    task automatic finish_rsp(input string tag);
        sb_compare(tag);
        rsp_ready_i = 1'b1;
        cmd_valid_i = 1'b0;
        @(negedge wb_clk_i);
        check({tag, "_idle_rsp_valid"}, {31'b0, rsp_valid_o}, 32'd0);
        check({tag, "_idle_cmd_ready"}, {31'b0, cmd_ready_o}, 32'd1);
        rsp_ready_i = 1'b0;
    endtask

    // Called at a negedge while idle.
    task automatic run_txn(input vec_t v, input string tag);
        exp_t e;
        rsp_ready_i = (v.hold == 0);
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_dat_i   = v.dat;
        cmd_sel_i   = v.sel;
        cmd_valid_i = 1'b1;
        e.dat = v.exp_dat;
        e.err = v.exp_err;
        sb_q.push_back(e);
        check({tag, "_cmd_ready"}, {31'b0, cmd_ready_o}, 32'd1);
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        cmd_adr_i   = ~v.adr;
        cmd_dat_i   = ~v.dat;
        cmd_sel_i   = ~v.sel;
        cmd_we_i    = ~v.we;
        check({tag, "_cyc"}, {31'b0, wbm_cyc_o}, 32'd1);
        check({tag, "_stb"}, {31'b0, wbm_stb_o}, 32'd1);
        check({tag, "_we"},  {31'b0, wbm_we_o},  {31'b0, v.we});
        check({tag, "_adr"}, wbm_adr_o, v.adr);
        check({tag, "_dat"}, wbm_dat_o, v.we ? v.dat : 32'h0);
        check({tag, "_sel"}, {28'b0, wbm_sel_o}, {28'b0, v.sel});
        check({tag, "_bus_cmd_ready"}, {31'b0, cmd_ready_o}, 32'd0);
        for (int i = 0; i < v.waits; i++) begin
            @(negedge wb_clk_i);
            check({tag, "_wait_cyc"}, {31'b0, wbm_cyc_o}, 32'd1);
            check({tag, "_wait_adr"}, wbm_adr_o, v.adr);
            check({tag, "_wait_rsp_valid"}, {31'b0, rsp_valid_o}, 32'd0);
        end
        wbm_ack_i = v.ack;
        wbm_err_i = v.err;
        wbm_dat_i = v.sdat;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'hBAD0_BAD0;
        check({tag, "_cyc_drop"}, {31'b0, wbm_cyc_o}, 32'd0);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid_o}, 32'd1);
        if (v.hold > 0) begin
            cmd_valid_i = 1'b1;
            cmd_adr_i   = 32'h7777_0000;
        end
        for (int i = 0; i < v.hold; i++) begin
            check({tag, "_hold_valid"}, {31'b0, rsp_valid_o}, 32'd1);
            check({tag, "_hold_dat"}, rsp_dat_o, v.exp_dat);
            check({tag, "_hold_err"}, {31'b0, rsp_err_o}, {31'b0, v.exp_err});
            check({tag, "_hold_cmd_ready"}, {31'b0, cmd_ready_o}, 32'd0);
            check({tag, "_hold_cyc"}, {31'b0, wbm_cyc_o}, 32'd0);
            @(negedge wb_clk_i);
        end
        finish_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   cnt;

        vecs[0] = '{we:1'b1, adr:32'h3000_0004, dat:32'hDEAD_BEEF, sel:4'hF, waits:2,
                    ack:1'b1, err:1'b0, sdat:32'hAAAA_5555, hold:0, exp_dat:32'h0, exp_err:1'b0};
        vecs[1] = '{we:1'b0, adr:32'h3000_0008, dat:32'h1111_2222, sel:4'hF, waits:0,
                    ack:1'b1, err:1'b0, sdat:32'h1234_5678, hold:0, exp_dat:32'h1234_5678, exp_err:1'b0};
        vecs[2] = '{we:1'b0, adr:32'h0000_0010, dat:32'h0, sel:4'hF, waits:1,
                    ack:1'b1, err:1'b1, sdat:32'hFFFF_FFFF, hold:0, exp_dat:32'h0, exp_err:1'b1};
        vecs[3] = '{we:1'b0, adr:32'h2000_0000, dat:32'h0, sel:4'h3, waits:1,
                    ack:1'b1, err:1'b0, sdat:32'hCAFE_F00D, hold:5, exp_dat:32'hCAFE_F00D, exp_err:1'b0};
        vecs[4] = '{we:1'b1, adr:32'h0000_0100, dat:32'h0000_0055, sel:4'h1, waits:0,
                    ack:1'b0, err:1'b1, sdat:32'h5A5A_5A5A, hold:2, exp_dat:32'h0, exp_err:1'b1};
        vecs[5] = '{we:1'b0, adr:32'h0000_0200, dat:32'h0, sel:4'hC, waits:3,
                    ack:1'b0, err:1'b1, sdat:32'h9999_9999, hold:0, exp_dat:32'h0, exp_err:1'b1};

        wb_rst_i    = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h0;
        cmd_dat_i   = 32'h0;
        cmd_sel_i   = 4'h0;
        rsp_ready_i = 1'b0;
        wbm_dat_i   = 32'h0;
        wbm_ack_i   = 1'b0;
        wbm_err_i   = 1'b0;

        // Reset state.
        #2;
        check("rst_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
        check("rst_cyc",       {31'b0, wbm_cyc_o},   32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_adr",       wbm_adr_o,            32'h0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        #1;
        check("rel_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        @(negedge wb_clk_i);

        // ack/err while idle must be ignored.
        wbm_ack_i = 1'b1;
        wbm_err_i = 1'b1;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check("idle_ack_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("idle_ack_cyc",       {31'b0, wbm_cyc_o},   32'd0);
        check("idle_ack_cmd_ready", {31'b0, cmd_ready_o}, 32'd1);
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-BUS: cyc/stb drop asynchronously, no response afterwards.
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h4000_0000;
        cmd_sel_i   = 4'hF;
        cmd_valid_i = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
        check("mid_cyc_before", {31'b0, wbm_cyc_o}, 32'd1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("mid_cyc_async", {31'b0, wbm_cyc_o},   32'd0);
        check("mid_stb_async", {31'b0, wbm_stb_o},   32'd0);
        check("mid_cmd_ready", {31'b0, cmd_ready_o}, 32'd0);
        @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid_o || wbm_cyc_o) cnt++;
            @(negedge wb_clk_i);
        end
        check("mid_no_rsp", cnt, 32'd0);
        run_txn(vecs[1], "post_rst");

        // Timeout behaviour.
        cmd_we_i    = 1'b0;
        cmd_adr_i   = 32'h5000_0000;
        cmd_sel_i   = 4'hF;
        cmd_valid_i = 1'b1;
        @(negedge wb_clk_i);
        cmd_valid_i = 1'b0;
`ifdef WBM_TIMEOUT_EN
        e.dat = 32'h0;
        e.err = 1'b1;
        sb_q.push_back(e);
        cnt = 0;
        for (int i = 0; i < 30 && !rsp_valid_o; i++) begin
            if (wbm_cyc_o) cnt++;
            @(negedge wb_clk_i);
        end
        check("tmo_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("tmo_cyc_cycles", cnt, 32'd4);
        check("tmo_cyc_drop", {31'b0, wbm_cyc_o}, 32'd0);
        finish_rsp("tmo");
`else
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            if (!wbm_cyc_o || rsp_valid_o) cnt++;
            @(negedge wb_clk_i);
        end
        check("notmo_cyc_held", cnt, 32'd0);
        e.dat = 32'h600D_600D;
        e.err = 1'b0;
        sb_q.push_back(e);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h600D_600D;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        check("notmo_rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        finish_rsp("notmo");
`endif

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
